// File: rtl/peridot_scif_pkg.sv
// Shared constants and FSM state encodings for the PERIDOT SCIF byte bridge.
package peridot_scif_pkg;

    localparam int unsigned SCIF_DATA_BITS  = 8;
    localparam int unsigned SCIF_FRAME_BITS = 10;
    localparam int unsigned SCIF_CNT_W      = $clog2(SCIF_FRAME_BITS);

    typedef logic [SCIF_CNT_W-1:0] scif_cnt_t;

    localparam scif_cnt_t SCIF_LAST_DATA = scif_cnt_t'(SCIF_DATA_BITS);

    typedef enum logic [1:0] {DesHunt, DesIdle, DesBits} des_state_e;
    typedef enum logic [1:0] {SerIdle, SerStart, SerData, SerStop} ser_state_e;

endpackage

// File: rtl/peridot_scif_bridge_sync_if.sv
// Byte-stream, SCIF pin and status bundle of the bridge; slave is the bridge side.
interface peridot_scif_bridge_sync_if #(
    parameter int unsigned H2F_DEPTH_LOG2 = 4,
    parameter int unsigned F2H_DEPTH_LOG2 = 4
);
    logic                      out_ready;
    logic                      out_valid;
    logic [7:0]                out_data;
    logic                      in_valid;
    logic [7:0]                in_data;
    logic                      in_ready;
    logic                      scif_sclk;
    logic                      scif_txd;
    logic                      scif_txr_n;
    logic                      scif_rxd;
    logic                      scif_rxr_n;
    logic                      err_clear;
    logic                      frame_err;
    logic                      overflow;
    logic [H2F_DEPTH_LOG2:0]   h2f_level;
    logic [F2H_DEPTH_LOG2:0]   f2h_level;

    modport slave (
        input  out_ready, in_valid, in_data, scif_sclk, scif_txd, scif_rxr_n, err_clear,
        output out_valid, out_data, in_ready, scif_txr_n, scif_rxd, frame_err, overflow,
               h2f_level, f2h_level
    );

    modport master (
        output out_ready, in_valid, in_data, scif_sclk, scif_txd, scif_rxr_n, err_clear,
        input  out_valid, out_data, in_ready, scif_txr_n, scif_rxd, frame_err, overflow,
               h2f_level, f2h_level
    );

endinterface

// File: rtl/peridot_scif_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; pushes when full and pops when empty are ignored.
module peridot_scif_sync_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  pop,
    output logic [WIDTH-1:0]      rdata,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count_q == (DEPTH_LOG2 + 1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr_q];
    assign level   = count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Storage is not reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/peridot_scif_bridge_sync.sv
// SCIF serial link to Avalon-ST byte-stream bridge with SCLK oversampled in the clk domain.
module peridot_scif_bridge_sync
    import peridot_scif_pkg::*;
#(
    parameter int unsigned H2F_DEPTH_LOG2 = 4,
    parameter int unsigned F2H_DEPTH_LOG2 = 4,
    parameter int unsigned H2F_MARGIN     = 2,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input logic                       clk,
    input logic                       reset_n,
    peridot_scif_bridge_sync_if.slave bus
);

    localparam int unsigned H2F_DEPTH = 1 << H2F_DEPTH_LOG2;

    logic [SYNC_STAGES-1:0] sclk_sync_q, txd_sync_q, rxr_n_sync_q;
    logic                   sclk_prev_q, txd_smp_q, rxr_n_smp_q;
    logic                   rise_ev_q, fall_ev_q;
    logic                   sclk_s;

    des_state_e                des_state_q;
    scif_cnt_t                 des_cnt_q;
    logic [SCIF_DATA_BITS-1:0] des_shift_q;
    logic                      stop_ev, h2f_push, h2f_pop, h2f_full, h2f_empty;
    logic [7:0]                h2f_rdata;
    logic [H2F_DEPTH_LOG2:0]   h2f_level;

    ser_state_e                ser_state_q;
    scif_cnt_t                 ser_cnt_q;
    logic [SCIF_DATA_BITS-1:0] tx_byte_q;
    logic                      rxr_q, f2h_avail_q, start_ok, f2h_push, f2h_pop;
    logic                      f2h_full, f2h_empty;
    logic [7:0]                f2h_rdata;
    logic [F2H_DEPTH_LOG2:0]   f2h_level;

    logic txr_n_q, rxd_q, frame_err_q, overflow_q, rst_done_q, txr_hi;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];

    // Strobes are registered, so the sampled txd/rxr_n are delayed one cycle to stay aligned.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync_q  <= '0;
            txd_sync_q   <= '1;
            rxr_n_sync_q <= '1;
            sclk_prev_q  <= 1'b0;
            txd_smp_q    <= 1'b1;
            rxr_n_smp_q  <= 1'b1;
            rise_ev_q    <= 1'b0;
            fall_ev_q    <= 1'b0;
        end else begin
            sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], bus.scif_sclk};
            txd_sync_q   <= {txd_sync_q[SYNC_STAGES-2:0], bus.scif_txd};
            rxr_n_sync_q <= {rxr_n_sync_q[SYNC_STAGES-2:0], bus.scif_rxr_n};
            sclk_prev_q  <= sclk_s;
            txd_smp_q    <= txd_sync_q[SYNC_STAGES-1];
            rxr_n_smp_q  <= rxr_n_sync_q[SYNC_STAGES-1];
            rise_ev_q    <= sclk_s && !sclk_prev_q;
            fall_ev_q    <= !sclk_s && sclk_prev_q;
        end
    end

    assign stop_ev  = rise_ev_q && (des_state_q == DesBits) && (des_cnt_q == SCIF_LAST_DATA);
    assign h2f_push = stop_ev && txd_smp_q && !h2f_full;
    assign h2f_pop  = !h2f_empty && bus.out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            des_state_q <= DesHunt;
            des_cnt_q   <= '0;
            des_shift_q <= '0;
        end else if (rise_ev_q) begin
            unique case (des_state_q)
                DesHunt: if (txd_smp_q) des_state_q <= DesIdle;
                DesIdle: begin
                    if (!txd_smp_q) begin
                        des_state_q <= DesBits;
                        des_cnt_q   <= '0;
                    end
                end
                DesBits: begin
                    if (des_cnt_q == SCIF_LAST_DATA) begin
                        des_state_q <= txd_smp_q ? DesIdle : DesHunt;
                    end else begin
                        des_shift_q <= {txd_smp_q, des_shift_q[SCIF_DATA_BITS-1:1]};
                        des_cnt_q   <= des_cnt_q + 1'b1;
                    end
                end
                default: des_state_q <= DesHunt;
            endcase
        end
    end

    peridot_scif_sync_fifo #(
        .DEPTH_LOG2 (H2F_DEPTH_LOG2),
        .WIDTH      (8)
    ) u_h2f_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (h2f_push),
        .wdata   (des_shift_q),
        .pop     (h2f_pop),
        .rdata   (h2f_rdata),
        .full    (h2f_full),
        .empty   (h2f_empty),
        .level   (h2f_level)
    );

    // f2h_avail_q gives a pushed byte at least two clocks before its start bit can go out.
    assign start_ok = rxr_q && f2h_avail_q && !f2h_empty;
    assign f2h_pop  = fall_ev_q && start_ok &&
                      ((ser_state_q == SerIdle) || (ser_state_q == SerStop));
    assign f2h_push = bus.in_valid && !f2h_full && rst_done_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ser_state_q <= SerIdle;
            ser_cnt_q   <= '0;
            tx_byte_q   <= '0;
            rxd_q       <= 1'b1;
        end else if (fall_ev_q) begin
            unique case (ser_state_q)
                SerIdle, SerStop: begin
                    if (start_ok) begin
                        rxd_q       <= 1'b0;
                        tx_byte_q   <= f2h_rdata;
                        ser_state_q <= SerStart;
                    end else begin
                        rxd_q       <= 1'b1;
                        ser_state_q <= SerIdle;
                    end
                end
                SerStart: begin
                    rxd_q       <= tx_byte_q[0];
                    tx_byte_q   <= tx_byte_q >> 1;
                    ser_cnt_q   <= scif_cnt_t'(1);
                    ser_state_q <= SerData;
                end
                SerData: begin
                    if (ser_cnt_q == SCIF_LAST_DATA) begin
                        rxd_q       <= 1'b1;
                        ser_state_q <= SerStop;
                    end else begin
                        rxd_q     <= tx_byte_q[0];
                        tx_byte_q <= tx_byte_q >> 1;
                        ser_cnt_q <= ser_cnt_q + 1'b1;
                    end
                end
                default: ser_state_q <= SerIdle;
            endcase
        end
    end

    peridot_scif_sync_fifo #(
        .DEPTH_LOG2 (F2H_DEPTH_LOG2),
        .WIDTH      (8)
    ) u_f2h_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (f2h_push),
        .wdata   (bus.in_data),
        .pop     (f2h_pop),
        .rdata   (f2h_rdata),
        .full    (f2h_full),
        .empty   (f2h_empty),
        .level   (f2h_level)
    );

    assign txr_hi = (32'(h2f_level) + H2F_MARGIN) >= H2F_DEPTH;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            txr_n_q     <= 1'b1;
            rxr_q       <= 1'b0;
            f2h_avail_q <= 1'b0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            rst_done_q  <= 1'b0;
        end else begin
            rst_done_q  <= 1'b1;
            f2h_avail_q <= !f2h_empty;
            if (fall_ev_q) txr_n_q <= txr_hi;
            if (rise_ev_q) rxr_q <= !rxr_n_smp_q;
            if (bus.err_clear) begin
                frame_err_q <= 1'b0;
                overflow_q  <= 1'b0;
            end else begin
                if (stop_ev && !txd_smp_q) frame_err_q <= 1'b1;
                if (stop_ev && txd_smp_q && h2f_full) overflow_q <= 1'b1;
            end
        end
    end

    assign bus.out_valid  = !h2f_empty;
    assign bus.out_data   = h2f_empty ? 8'h00 : h2f_rdata;
    assign bus.in_ready   = rst_done_q && !f2h_full;
    assign bus.scif_txr_n = txr_n_q;
    assign bus.scif_rxd   = rxd_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.overflow   = overflow_q;
    assign bus.h2f_level  = h2f_level;
    assign bus.f2h_level  = f2h_level;

endmodule

// File: tb/tb_peridot_scif_bridge_sync.sv
// Bench for peridot_scif_bridge_sync: vector table for H2F frames plus scoreboarded sequences.
module tb_peridot_scif_bridge_sync;

    localparam int unsigned HALF = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    peridot_scif_bridge_sync_if #(.H2F_DEPTH_LOG2(4), .F2H_DEPTH_LOG2(4)) bus ();

    peridot_scif_bridge_sync #(
        .H2F_DEPTH_LOG2 (4),
        .F2H_DEPTH_LOG2 (4),
        .H2F_MARGIN     (2),
        .SYNC_STAGES    (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_fe;
        logic       clear;
    } h2f_vec_t;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] h2f_exp[$];
    logic [7:0] f2h_exp[$];
    logic       rx_hist[$];
    int         rx_cnt = 0;
    int         rx_frames = 0;
    logic [7:0] rx_byte = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Host-side receiver: decodes the rxd samples taken just before each falling SCLK edge.
    task automatic rx_sample(input logic s);
        rx_hist.push_back(s);
        if (rx_cnt == 0) begin
            if (s == 1'b0) rx_cnt = 1;
        end else if (rx_cnt <= 8) begin
            rx_byte[rx_cnt-1] = s;
            rx_cnt++;
        end else begin
            rx_cnt = 0;
            rx_frames++;
            chk("f2h_stop_bit", 32'(s), 32'd1);
            if (f2h_exp.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL f2h_unexpected: got byte %0h, expected none", rx_byte);
            end else begin
                chk("f2h_data", 32'(rx_byte), 32'(f2h_exp.pop_front()));
            end
        end
    endtask

    task automatic sclk_cycle(input logic b);
        bus.scif_txd = b;
        repeat (HALF) tick();
        bus.scif_sclk = 1'b1;
        repeat (HALF) tick();
        rx_sample(bus.scif_rxd);
        bus.scif_sclk = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic track);
        if (track) h2f_exp.push_back(d);
        sclk_cycle(1'b0);
        for (int i = 0; i < 8; i++) sclk_cycle(d[i]);
        sclk_cycle(stop);
        sclk_cycle(1'b1);
        sclk_cycle(1'b1);
    endtask

    task automatic f2h_push(input logic [7:0] d, input logic track);
        int w = 0;
        while (!bus.in_ready && w < 50) begin
            tick();
            w++;
        end
        chk("in_ready_before_push", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        tick();
        bus.in_valid = 1'b0;
        if (track) f2h_exp.push_back(d);
    endtask

    task automatic check_reset(input string p);
        chk({p, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({p, "_out_data"}, 32'(bus.out_data), 32'd0);
        chk({p, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        chk({p, "_txr_n"}, 32'(bus.scif_txr_n), 32'd1);
        chk({p, "_rxd"}, 32'(bus.scif_rxd), 32'd1);
        chk({p, "_frame_err"}, 32'(bus.frame_err), 32'd0);
        chk({p, "_overflow"}, 32'(bus.overflow), 32'd0);
        chk({p, "_h2f_level"}, 32'(bus.h2f_level), 32'd0);
        chk({p, "_f2h_level"}, 32'(bus.f2h_level), 32'd0);
    endtask

    function automatic int first_zero();
        foreach (rx_hist[i]) if (rx_hist[i] == 1'b0) return i;
        return -1;
    endfunction

    task automatic clear_flags();
        bus.err_clear = 1'b1;
        tick();
        bus.err_clear = 1'b0;
        tick();
    endtask

    // H2F scoreboard: every accepted output byte must match the oldest expected one.
    always @(negedge clk) begin
        if (reset_n && bus.out_valid && bus.out_ready) begin
            if (h2f_exp.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL h2f_unexpected: got byte %0h, expected none", bus.out_data);
            end else begin
                chk("h2f_data", 32'(bus.out_data), 32'(h2f_exp.pop_front()));
            end
        end
    end

    initial begin
        #10000000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog");
    end

    initial begin
        h2f_vec_t vecs[6];
        logic     exp_bits[10];
        int       s;
        int       zeros;
        int       frames0;

        vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_fe: 1'b0, clear: 1'b0};
        vecs[1] = '{data: 8'h3C, stop: 1'b1, exp_fe: 1'b0, clear: 1'b0};
        vecs[2] = '{data: 8'h55, stop: 1'b0, exp_fe: 1'b1, clear: 1'b0};
        vecs[3] = '{data: 8'h12, stop: 1'b1, exp_fe: 1'b1, clear: 1'b1};
        vecs[4] = '{data: 8'h00, stop: 1'b1, exp_fe: 1'b0, clear: 1'b0};
        vecs[5] = '{data: 8'hFF, stop: 1'b1, exp_fe: 1'b0, clear: 1'b0};
        exp_bits = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        bus.out_ready  = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_data    = 8'h00;
        bus.scif_sclk  = 1'b0;
        bus.scif_txd   = 1'b1;
        bus.scif_rxr_n = 1'b1;
        bus.err_clear  = 1'b0;

        repeat (3) tick();
        check_reset("reset");
        reset_n = 1'b1;
        repeat (3) tick();
        chk("in_ready_after_reset", 32'(bus.in_ready), 32'd1);
        sclk_cycle(1'b1);
        sclk_cycle(1'b1);

        // H2F vector table
        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].stop);
            chk($sformatf("vec%0d_frame_err", i), 32'(bus.frame_err), 32'(vecs[i].exp_fe));
            chk($sformatf("vec%0d_overflow", i), 32'(bus.overflow), 32'd0);
            chk($sformatf("vec%0d_h2f_level", i), 32'(bus.h2f_level), 32'd0);
            chk($sformatf("vec%0d_delivered", i), 32'(h2f_exp.size()), 32'd0);
            if (vecs[i].clear) begin
                clear_flags();
                chk($sformatf("vec%0d_frame_err_cleared", i), 32'(bus.frame_err), 32'd0);
            end
        end

        // Overflow and TXR flow control
        bus.out_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            send_frame(8'h40 + 8'(i), 1'b1, i < 16);
            if (i == 12) begin
                chk("ovf_txr_n_after13", 32'(bus.scif_txr_n), 32'd0);
                chk("ovf_level_after13", 32'(bus.h2f_level), 32'd13);
            end
            if (i == 13) chk("ovf_txr_n_after14", 32'(bus.scif_txr_n), 32'd1);
            if (i == 15) chk("ovf_flag_before_drop", 32'(bus.overflow), 32'd0);
        end
        chk("ovf_flag", 32'(bus.overflow), 32'd1);
        chk("ovf_level_full", 32'(bus.h2f_level), 32'd16);
        chk("ovf_frame_err", 32'(bus.frame_err), 32'd0);
        bus.out_ready = 1'b1;
        repeat (24) tick();
        chk("ovf_drained", 32'(h2f_exp.size()), 32'd0);
        chk("ovf_level_empty", 32'(bus.h2f_level), 32'd0);
        sclk_cycle(1'b1);
        chk("ovf_txr_n_released", 32'(bus.scif_txr_n), 32'd0);
        clear_flags();
        chk("ovf_flag_cleared", 32'(bus.overflow), 32'd0);

        // F2H single frame bit pattern
        bus.scif_rxr_n = 1'b0;
        f2h_push(8'h81, 1'b1);
        rx_hist.delete();
        repeat (14) sclk_cycle(1'b1);
        s = first_zero();
        if (s < 0 || s + 9 >= rx_hist.size()) begin
            chk("f2h81_frame_found", 32'd0, 32'd1);
        end else begin
            for (int k = 0; k < 10; k++) begin
                chk($sformatf("f2h81_bit%0d", k), 32'(rx_hist[s+k]), 32'(exp_bits[k]));
            end
        end
        chk("f2h81_level", 32'(bus.f2h_level), 32'd0);

        // F2H held by rxr_n, then released back-to-back
        bus.scif_rxr_n = 1'b1;
        sclk_cycle(1'b1);
        sclk_cycle(1'b1);
        f2h_push(8'h11, 1'b1);
        f2h_push(8'h22, 1'b1);
        f2h_push(8'h33, 1'b1);
        rx_hist.delete();
        repeat (15) sclk_cycle(1'b1);
        zeros = 0;
        foreach (rx_hist[i]) if (rx_hist[i] == 1'b0) zeros++;
        chk("hold_rxd_idle", 32'(zeros), 32'd0);
        chk("hold_f2h_level", 32'(bus.f2h_level), 32'd3);
        bus.scif_rxr_n = 1'b0;
        rx_hist.delete();
        frames0 = rx_frames;
        repeat (36) sclk_cycle(1'b1);
        chk("b2b_frames", 32'(rx_frames - frames0), 32'd3);
        s = first_zero();
        if (s < 0 || s + 20 >= rx_hist.size()) begin
            chk("b2b_frame_found", 32'd0, 32'd1);
        end else begin
            chk("b2b_start2", 32'(rx_hist[s+10]), 32'd0);
            chk("b2b_start3", 32'(rx_hist[s+20]), 32'd0);
        end
        chk("b2b_f2h_level", 32'(bus.f2h_level), 32'd0);

        // Reset in the middle of frames in both directions
        bus.out_ready = 1'b0;
        send_frame(8'h77, 1'b1, 1'b0);
        chk("mid_h2f_level", 32'(bus.h2f_level), 32'd1);
        f2h_push(8'hC3, 1'b0);
        f2h_push(8'hD4, 1'b0);
        sclk_cycle(1'b0);
        for (int i = 0; i < 4; i++) sclk_cycle(1'b1);
        reset_n = 1'b0;
        #2;
        check_reset("midrst");
        rx_cnt = 0;
        bus.scif_txd = 1'b1;
        repeat (3) tick();
        reset_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        sclk_cycle(1'b1);
        sclk_cycle(1'b1);
        f2h_push(8'hE7, 1'b1);
        send_frame(8'h9E, 1'b1, 1'b1);
        repeat (4) sclk_cycle(1'b1);
        chk("post_h2f_delivered", 32'(h2f_exp.size()), 32'd0);
        chk("post_f2h_delivered", 32'(f2h_exp.size()), 32'd0);
        chk("post_frame_err", 32'(bus.frame_err), 32'd0);
        chk("post_overflow", 32'(bus.overflow), 32'd0);
        chk("post_levels", 32'(bus.h2f_level) + 32'(bus.f2h_level), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
